// File: rtl/disk_block_reader_if.sv
// Read port between the block reader and the synchronous disk memory.
// Data returns in the cycle after the cycle in which mem_en is high.
interface disk_block_reader_if #(
    parameter int DATA_W = 32
);
    logic              mem_en;
    logic [8:0]        mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_en, output mem_addr, input  mem_data);
    modport slave  (input  mem_en, input  mem_addr, output mem_data);
endinterface

// File: rtl/disk_block_reader.sv
// Fetches a 4-word block from disk memory whenever the requested base address
// differs from the block currently held, re-fetching until the request settles.
module disk_block_reader #(
    parameter  int DATA_W = 32,
    localparam int WORDS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8:0]              addr,
    disk_block_reader_if.master     mem,
    output logic [WORDS*DATA_W-1:0] block_data,
    output logic [8:0]              loaded_addr,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [8:0]              req_q, req_d;
    logic [1:0]              index_q, index_d;
    logic                    mem_en_q, mem_en_d;
    logic [8:0]              mem_addr_q, mem_addr_d;
    logic                    rd_pending_q;
    logic [1:0]              rd_idx_q;
    logic [WORDS*DATA_W-1:0] block_q;
    logic [8:0]              loaded_q, loaded_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    start;

    // NOTE: every signal gets its default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        index_d    = index_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        loaded_d   = loaded_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        start      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!valid_q || addr != loaded_q) start = 1'b1;
            end
            ISSUE: begin
                if (index_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    mem_en_d   = 1'b1;
                    index_d    = index_q + 2'd1;
                    mem_addr_d = req_q + 9'(index_q) + 9'd1;
                end
            end
            DRAIN: begin
                // A request that moved during the fetch is honoured only now.
                if (addr == req_q) begin
                    loaded_d = req_q;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    index_d  = 2'd0;
                    state_d  = IDLE;
                end else begin
                    start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            req_d      = addr;
            valid_d    = 1'b0;
            busy_d     = 1'b1;
            mem_en_d   = 1'b1;
            mem_addr_d = addr;
            index_d    = 2'd0;
            state_d    = ISSUE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            index_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            rd_pending_q <= 1'b0;
            rd_idx_q     <= '0;
            // NOTE: the block register is reset because it is a visible output that must read zero after reset.
            block_q      <= '0;
            loaded_q     <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            index_q      <= index_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            // A word issued this cycle arrives next cycle; remember which slot it fills.
            rd_pending_q <= mem_en_q;
            rd_idx_q     <= index_q;
            if (rd_pending_q) block_q[int'(rd_idx_q)*DATA_W +: DATA_W] <= mem.mem_data;
            loaded_q     <= loaded_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem.mem_en   = mem_en_q;
    assign mem.mem_addr = mem_addr_q;
    assign block_data   = block_q;
    assign loaded_addr  = loaded_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_disk_block_reader.sv
// Directed bench for disk_block_reader: memory word i holds 0x1000+i; table of
// block fetches plus hand sequences for retarget, idle hold and mid-fetch reset.
module tb_disk_block_reader;

    localparam int DATA_W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [8:0]   addr;
    logic [127:0] block_data;
    logic [8:0]   loaded_addr;
    logic         valid, busy, done;

    disk_block_reader_if #(.DATA_W(DATA_W)) mif ();

    disk_block_reader #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .mem        (mif.master),
        .block_data (block_data),
        .loaded_addr(loaded_addr),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: word i = 0x1000 + i.
    always @(posedge clk) begin
        if (mif.mem_en) mif.mem_data <= 32'h1000 + {23'd0, mif.mem_addr};
    end

    logic [8:0] trace[$];
    int         viol = 0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        if (mif.mem_en) trace.push_back(mif.mem_addr);
        if (busy && valid) viol++;
        if (done && prev_done) viol++;
        prev_done = done;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        check("done_seen", 128'(done), 128'd1);
    endtask

    typedef struct {
        logic [8:0]      a;
        logic [3:0][8:0] seq;
        logic [127:0]    blk;
    } vec_t;

    task automatic fetch_check(input vec_t v);
        int n;
        trace.delete();
        addr = v.a;
        wait_done(n);
        check("latency", 128'(n), 128'd6);
        check("valid", 128'(valid), 128'd1);
        check("busy_idle", 128'(busy), 128'd0);
        check("loaded_addr", 128'(loaded_addr), 128'(v.a));
        check("block_data", block_data, v.blk);
        check("issue_count", 128'(trace.size()), 128'd4);
        for (int k = 0; k < 4 && k < trace.size(); k++)
            check("mem_addr_seq", 128'(trace[k]), 128'(v.seq[k]));
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int n, dones, busy_gap, cnt_en, cnt_done, cnt_inval;

        vecs[0] = '{9'd100, {9'd103, 9'd102, 9'd101, 9'd100},
                    128'h00001067_00001066_00001065_00001064};
        vecs[1] = '{9'd510, {9'd1, 9'd0, 9'd511, 9'd510},
                    128'h00001001_00001000_000011FF_000011FE};
        vecs[2] = '{9'd508, {9'd511, 9'd510, 9'd509, 9'd508},
                    128'h000011FF_000011FE_000011FD_000011FC};
        vecs[3] = '{9'd4, {9'd7, 9'd6, 9'd5, 9'd4},
                    128'h00001007_00001006_00001005_00001004};

        // Reset state.
        rst  = 1'b0;
        addr = 9'd0;
        repeat (3) @(negedge clk);
        check("rst_mem_en", 128'(mif.mem_en), 128'd0);
        check("rst_mem_addr", 128'(mif.mem_addr), 128'd0);
        check("rst_valid", 128'(valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_block", block_data, 128'd0);
        check("rst_loaded", 128'(loaded_addr), 128'd0);

        // First fetch after reset release, addr 0.
        rst = 1'b1;
        fetch_check('{9'd0, {9'd3, 9'd2, 9'd1, 9'd0},
                      128'h00001003_00001002_00001001_00001000});

        // Retarget 4 -> 8 in the second ISSUE cycle.
        trace.delete();
        addr     = 9'd4;
        n        = 0;
        dones    = 0;
        busy_gap = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 2) addr = 9'd8;
            if (done) dones++;
            if (n < 11 && (!busy || valid)) busy_gap++;
        end while (!valid && n < 40);
        check("retarget_latency", 128'(n), 128'd11);
        check("retarget_dones", 128'(dones), 128'd1);
        check("retarget_busy_held", 128'(busy_gap), 128'd0);
        check("retarget_loaded", 128'(loaded_addr), 128'd8);
        check("retarget_block", block_data, 128'h0000100B_0000100A_00001009_00001008);
        check("retarget_issues", 128'(trace.size()), 128'd8);
        for (int k = 0; k < 8 && k < trace.size(); k++)
            check("retarget_seq", 128'(trace[k]), 128'(9'd4 + 9'(k)));
        @(posedge clk);
        @(negedge clk);
        check("retarget_done_pulse", 128'(done), 128'd0);

        // Table of plain fetches, ending on addr 4.
        for (int i = 0; i < 4; i++) fetch_check(vecs[i]);

        // Stable addr 4: nothing more happens.
        cnt_en    = 0;
        cnt_done  = 0;
        cnt_inval = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (mif.mem_en) cnt_en++;
            if (done) cnt_done++;
            if (!valid) cnt_inval++;
        end
        check("hold_mem_en", 128'(cnt_en), 128'd0);
        check("hold_done", 128'(cnt_done), 128'd0);
        check("hold_valid", 128'(cnt_inval), 128'd0);

        // Reset asserted during DRAIN of a fetch of 12.
        addr = 9'd12;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("drain_mem_en", 128'(mif.mem_en), 128'd0);
        check("drain_busy", 128'(busy), 128'd1);
        #2 rst = 1'b0;
        #1;
        check("async_mem_en", 128'(mif.mem_en), 128'd0);
        check("async_mem_addr", 128'(mif.mem_addr), 128'd0);
        check("async_valid", 128'(valid), 128'd0);
        check("async_busy", 128'(busy), 128'd0);
        check("async_done", 128'(done), 128'd0);
        check("async_block", block_data, 128'd0);
        check("async_loaded", 128'(loaded_addr), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        fetch_check('{9'd12, {9'd15, 9'd14, 9'd13, 9'd12},
                      128'h0000100F_0000100E_0000100D_0000100C});

        check("busy_valid_done_rules", 128'(viol), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
